// File: rtl/sum_arbiter_if.sv
// Client-side bundle of the sum_arbiter: per-client request/operands in,
// one-hot acknowledge, shared result and busy flag out.
interface sum_arbiter_if #(
    parameter int W     = 16,
    parameter int N_CLI = 4
);
    logic [N_CLI-1:0]   req;
    logic [N_CLI*W-1:0] a_flat;
    logic [N_CLI*W-1:0] b_flat;
    logic [N_CLI-1:0]   ack;
    logic [W-1:0]       res;
    logic               busy;

    modport master (
        output req, a_flat, b_flat,
        input  ack, res, busy
    );

    modport slave (
        input  req, a_flat, b_flat,
        output ack, res, busy
    );
endinterface

// File: rtl/sum_arbiter.sv
// Round-robin arbiter sharing one external adder between N_CLI requesters.
// Optional grant/conflict statistics are enabled with SUM_ARB_STATS_EN.
//
// state | meaning
// IDLE  | no operation in flight
// ADD   | granted client's operands driven onto the adder
// ACK   | result registered, ack pulsed; re-arbitrate with grantee masked
module sum_arbiter #(
    parameter int W     = 16,
    parameter int N_CLI = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    sum_arbiter_if.slave  bus,
    output logic [W-1:0]  o_sum_in_a,
    output logic [W-1:0]  o_sum_in_b,
    input  logic [W-1:0]  i_sum_out
`ifdef SUM_ARB_STATS_EN
    ,
    output logic [N_CLI*16-1:0] o_gnt_cnt_flat,
    output logic [15:0]         o_conflict_cnt
`endif
);

    localparam int IDX_W = (N_CLI > 1) ? $clog2(N_CLI) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_gnt_idx;
    logic [IDX_W-1:0] w_winner;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [N_CLI-1:0] r_ack;
    logic [N_CLI-1:0] w_elig;
    logic [N_CLI-1:0] w_gnt_mask;
    logic [W-1:0]     r_res;
    logic             w_found;
    logic             w_grant;
    logic [W-1:0]     w_a [N_CLI];
    logic [W-1:0]     w_b [N_CLI];

    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_CLI) s = s - N_CLI;
        return IDX_W'(s);
    endfunction

    for (genvar i = 0; i < N_CLI; i++) begin : g_unpack
        assign w_a[i] = bus.a_flat[i*W +: W];
        assign w_b[i] = bus.b_flat[i*W +: W];
    end

    assign w_gnt_mask = N_CLI'(1) << r_gnt_idx;

    // The client just acked still holds req on the ACK edge, so it is masked.
    always_comb begin
        w_elig   = bus.req;
        w_found  = 1'b0;
        w_winner = '0;
        if (r_state == ACK) w_elig = bus.req & ~w_gnt_mask;
        for (int k = 0; k < N_CLI; k++) begin
            if (!w_found && w_elig[rr_idx(r_ptr, k)]) begin
                w_found  = 1'b1;
                w_winner = rr_idx(r_ptr, k);
            end
        end
    end

    assign w_ptr_nxt = (w_winner == IDX_W'(N_CLI - 1)) ? '0 : w_winner + 1'b1;
    assign w_grant   = w_found && (r_state != ADD);

    always_comb begin
        w_state_nxt = r_state;
        o_sum_in_a  = '0;
        o_sum_in_b  = '0;
        case (r_state)
            IDLE: begin
                if (w_found) w_state_nxt = ADD;
            end
            ADD: begin
                o_sum_in_a  = w_a[r_gnt_idx];
                o_sum_in_b  = w_b[r_gnt_idx];
                w_state_nxt = ACK;
            end
            ACK: begin
                w_state_nxt = w_found ? ADD : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr     <= '0;
            r_gnt_idx <= '0;
            r_ack     <= '0;
            r_res     <= '0;
        end else begin
            r_ack <= '0;
            if (w_grant) begin
                r_gnt_idx <= w_winner;
                r_ptr     <= w_ptr_nxt;
            end
            if (r_state == ADD) begin
                r_res <= i_sum_out;
                r_ack <= w_gnt_mask;
            end
        end
    end

    assign bus.ack  = r_ack;
    assign bus.res  = r_res;
    assign bus.busy = (r_state == ADD) || (r_state == ACK);

`ifdef SUM_ARB_STATS_EN
    logic [15:0] r_gnt_cnt [N_CLI];
    logic [15:0] r_conflict_cnt;
    logic        w_multi;

    assign w_multi = w_grant && ($countones(w_elig) > 1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < N_CLI; i++) r_gnt_cnt[i] <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_grant && (r_gnt_cnt[w_winner] != 16'hFFFF))
                r_gnt_cnt[w_winner] <= r_gnt_cnt[w_winner] + 16'd1;
            if (w_multi && (r_conflict_cnt != 16'hFFFF))
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    for (genvar i = 0; i < N_CLI; i++) begin : g_cnt_flat
        assign o_gnt_cnt_flat[i*16 +: 16] = r_gnt_cnt[i];
    end
    assign o_conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_sum_arbiter.sv
// Scoreboard bench for sum_arbiter: stimulus pushes expected (client, result)
// pairs, a negedge monitor pops and compares on every ack pulse.
module tb_sum_arbiter;
    localparam int W = 16;
    localparam int N = 4;

    typedef struct {
        int          idx;
        logic [15:0] res;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sum_in_a;
    logic [W-1:0] sum_in_b;
    logic [W-1:0] sum_out;
    logic [N-1:0] rereq;
    int           n_tests = 0;
    int           n_fail  = 0;
    int           n_acks  = 0;
    exp_t         exp_q[$];

    sum_arbiter_if #(.W(W), .N_CLI(N)) bus ();

`ifdef SUM_ARB_STATS_EN
    logic [N*16-1:0] gnt_cnt_flat;
    logic [15:0]     conflict_cnt;
`endif

    sum_arbiter #(.W(W), .N_CLI(N)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .bus        (bus),
        .o_sum_in_a (sum_in_a),
        .o_sum_in_b (sum_in_b),
        .i_sum_out  (sum_out)
`ifdef SUM_ARB_STATS_EN
        ,
        .o_gnt_cnt_flat (gnt_cnt_flat),
        .o_conflict_cnt (conflict_cnt)
`endif
    );

    // External adder stand-in
    assign sum_out = sum_in_a + sum_in_b;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        bus.a_flat[i*W +: W] = a;
        bus.b_flat[i*W +: W] = b;
    endtask

    task automatic push_exp(input int i, input logic [15:0] r);
        exp_t e;
        e.idx = i;
        e.res = r;
        exp_q.push_back(e);
    endtask

    task automatic wait_acks(input int target, input int budget);
        int c;
        c = 0;
        while (n_acks < target && c < budget) begin
            @(negedge clk);
            #1;
            c++;
        end
        chk("wait_acks", 64'(n_acks >= target), 64'd1);
    endtask

    // Monitor: every ack must match the head of the expected queue.
    initial begin : monitor
        exp_t         e;
        logic [N-1:0] oh;
        forever begin
            @(negedge clk);
            if (!rst && bus.ack != '0) begin
                n_acks++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got ack %0h expected none", bus.ack);
                end else begin
                    e  = exp_q.pop_front();
                    oh = N'(1) << e.idx;
                    chk("sb_ack", 64'(bus.ack), 64'(oh));
                    chk("sb_res", 64'(bus.res), 64'(e.res));
                end
            end
        end
    end

    // Client model: drop req just after the edge that sampled ack,
    // unless that client is flagged to re-request once.
    initial begin : release_proc
        logic [N-1:0] w;
        forever begin
            @(negedge clk);
            w = bus.ack;
            if (w != '0) begin
                @(posedge clk);
                #1;
                bus.req = bus.req & ~(w & ~rereq);
                rereq   = rereq & ~w;
            end
        end
    end

    initial begin : stim
        logic [N-1:0] exp_ack;
        bus.req    = '0;
        bus.a_flat = '0;
        bus.b_flat = '0;
        rereq      = '0;
        #1;
        chk("rst_ack",  64'(bus.ack),  64'd0);
        chk("rst_res",  64'(bus.res),  64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_sum_a", 64'(sum_in_a), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single client 2: 100 + 23
        @(posedge clk); #2;
        set_op(2, 16'd100, 16'd23);
        bus.req[2] = 1'b1;
        push_exp(2, 16'd123);
        @(negedge clk);
        chk("t1_pre_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        chk("t1_add_busy", 64'(bus.busy), 64'd1);
        chk("t1_add_ack",  64'(bus.ack),  64'd0);
        chk("t1_add_a",    64'(sum_in_a), 64'd100);
        chk("t1_add_b",    64'(sum_in_b), 64'd23);
        @(negedge clk);
        chk("t1_ack",      64'(bus.ack),  64'b0100);
        chk("t1_res",      64'(bus.res),  64'd123);
        chk("t1_ack_busy", 64'(bus.busy), 64'd1);
        chk("t1_ack_a",    64'(sum_in_a), 64'd0);
        @(negedge clk);
        chk("t1_end_ack",  64'(bus.ack),  64'd0);
        chk("t1_end_busy", 64'(bus.busy), 64'd0);
        chk("t1_res_hold", 64'(bus.res),  64'd123);

        // Reset, then all four clients together, twice
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        chk("rst2_res", 64'(bus.res), 64'd0);
        rst = 1'b0;
        for (int r = 0; r < 2; r++) begin
            @(posedge clk); #2;
            for (int i = 0; i < N; i++) begin
                set_op(i, 16'(i), 16'd10);
                push_exp(i, 16'(10 + i));
            end
            bus.req = 4'hF;
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                @(negedge clk);
                chk("t2_add_gap", 64'(bus.ack), 64'd0);
                @(negedge clk);
                exp_ack = N'(1) << k;
                chk("t2_ack_order", 64'(bus.ack), 64'(exp_ack));
            end
        end
`ifdef SUM_ARB_STATS_EN
        for (int i = 0; i < N; i++)
            chk("stat_gnt_cnt", 64'(gnt_cnt_flat[i*16 +: 16]), 64'd2);
        chk("stat_conflict", 64'(conflict_cnt), 64'd6);
`endif

        // Wrap: FFFF + 2
        @(posedge clk); #2;
        set_op(0, 16'hFFFF, 16'h0002);
        bus.req[0] = 1'b1;
        push_exp(0, 16'h0001);
        wait_acks(n_acks + 1, 10);
        chk("t3_res", 64'(bus.res), 64'h0001);

        // Client 1 re-requests while client 3 waits: order 1, 3, 1
        @(posedge clk); #2;
        set_op(1, 16'd7, 16'd8);
        set_op(3, 16'd1000, 16'd234);
        rereq[1]   = 1'b1;
        bus.req[1] = 1'b1;
        bus.req[3] = 1'b1;
        push_exp(1, 16'd15);
        push_exp(3, 16'd1234);
        push_exp(1, 16'd15);
        wait_acks(n_acks + 3, 20);

        // Reset during ADD discards the operation
        @(posedge clk); #2;
        set_op(2, 16'd5, 16'd6);
        bus.req[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t5_in_add", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", 64'(bus.busy), 64'd0);
        chk("t5_rst_ack",  64'(bus.ack),  64'd0);
        chk("t5_rst_res",  64'(bus.res),  64'd0);
        chk("t5_rst_a",    64'(sum_in_a), 64'd0);
        @(negedge clk);
        chk("t5_no_ack", 64'(bus.ack), 64'd0);
        push_exp(2, 16'd11);
        rst = 1'b0;
        wait_acks(n_acks + 1, 10);

        repeat (3) @(negedge clk);
        chk("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
